// File: rtl/mul_iterative_unit_if.sv
// Request/response bundle between the MiniAlu datapath (master) and the
// iterative multiplier (slave).
interface mul_iterative_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic               iStart;
  logic               iSigned;
  logic [WIDTH-1:0]   iA;
  logic [WIDTH-1:0]   iB;
  logic               oBusy;
  logic               oDone;
  logic [2*WIDTH-1:0] oResult;

  modport master (
    output iStart,
    output iSigned,
    output iA,
    output iB,
    input  oBusy,
    input  oDone,
    input  oResult
  );

  modport slave (
    input  iStart,
    input  iSigned,
    input  iA,
    input  iB,
    output oBusy,
    output oDone,
    output oResult
  );
endinterface

// File: rtl/mul_iterative_unit.sv
// Shift-add multiplier for MUL/IMUL: one partial product per RUN cycle, sign applied at the end.
// Define MUL_ITERATIVE_EARLY_EXIT_EN to leave RUN as soon as the remaining multiplier is zero.
module mul_iterative_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  mul_iterative_unit_if.slave  bus
);
  localparam int unsigned CountW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               stateQ;
  logic [2*WIDTH-1:0]   accQ;
  logic [2*WIDTH-1:0]   mcandQ;
  logic [WIDTH-1:0]     mplierQ;
  logic [CountW-1:0]    countQ;
  logic                 signQ;
  logic                 busyQ;
  logic                 doneQ;
  logic [2*WIDTH-1:0]   resultQ;

  logic                 startSign;
  logic [WIDTH-1:0]     startMagA;
  logic [WIDTH-1:0]     startMagB;
  logic [2*WIDTH-1:0]   accNext;
  logic [2*WIDTH-1:0]   resultNext;
  logic                 lastCount;
  logic                 runExit;

  // Magnitude of the most-negative value wraps to itself, which is its correct unsigned magnitude.
  always_comb begin
    startSign = bus.iSigned & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
    startMagA = (bus.iSigned && bus.iA[WIDTH-1]) ? (~bus.iA + 1'b1) : bus.iA;
    startMagB = (bus.iSigned && bus.iB[WIDTH-1]) ? (~bus.iB + 1'b1) : bus.iB;
  end

  always_comb begin
    accNext    = mplierQ[0] ? (accQ + mcandQ) : accQ;
    resultNext = signQ ? (~accNext + 1'b1) : accNext;
    lastCount  = (countQ == CountW'(WIDTH - 1));
  end

`ifdef MUL_ITERATIVE_EARLY_EXIT_EN
  assign runExit = lastCount || (mplierQ[WIDTH-1:1] == '0);
`else
  assign runExit = lastCount;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ  <= StIdle;
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      countQ  <= '0;
      signQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      resultQ <= '0;
    end else begin
      unique case (stateQ)
        StIdle, StDone: begin
          doneQ <= 1'b0;
          if (bus.iStart) begin
            stateQ  <= StRun;
            busyQ   <= 1'b1;
            signQ   <= startSign;
            mcandQ  <= {{WIDTH{1'b0}}, startMagA};
            mplierQ <= startMagB;
            accQ    <= '0;
            countQ  <= '0;
          end else begin
            stateQ <= StIdle;
          end
        end
        StRun: begin
          accQ    <= accNext;
          mcandQ  <= mcandQ << 1;
          mplierQ <= mplierQ >> 1;
          countQ  <= countQ + 1'b1;
          if (runExit) begin
            stateQ  <= StDone;
            busyQ   <= 1'b0;
            doneQ   <= 1'b1;
            resultQ <= resultNext;
          end
        end
        default: begin
          stateQ <= StIdle;
          busyQ  <= 1'b0;
          doneQ  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oBusy   = busyQ;
  assign bus.oDone   = doneQ;
  assign bus.oResult = resultQ;
endmodule

// File: doc/mul_iterative_unit.md
Name: mul_iterative_unit

Overview:
- Multi-cycle shift-add multiplier that acts as the responder to the MiniAlu datapath's MUL/IMUL requests.
- It replaces the single-cycle combinational product path.
- The ALU raises a start request with two operands and stalls while busy. The unit returns a full-width product with a one-cycle done pulse.
- It sits beside the ALU result mux and feeds rResult on completion.

Parameters:
- WIDTH, 16, operand width in bits. The product is 2*WIDTH bits.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- iStart  input  1  request strobe. Sampled only in IDLE or DONE.
- iSigned  input  1  1 = two's-complement operands (IMUL), 0 = unsigned (MUL). Sampled with iStart.
- iA  input  WIDTH  multiplicand. Sampled with iStart.
- iB  input  WIDTH  multiplier. Sampled with iStart.
- oBusy  output  1  high in RUN. The ALU stalls its pipeline while high.
- oDone  output  1  one-cycle pulse, high in DONE.
- oResult  output  2*WIDTH  product. Updated on entry to DONE and held until the next DONE.

Behaviour:
- Reset (async, any state): state=IDLE, oBusy=0, oDone=0, oResult=0, internal accumulator/counter/operand registers=0. An operation in flight when Reset asserts is discarded; no oDone is produced for it.
- States: IDLE, RUN, DONE. Transitions are on the rising edge of Clock.
- IDLE, iStart=1:
  - Latch the sign flag s = iSigned & (iA[MSB] ^ iB[MSB]).
  - Latch the magnitudes mcand = |iA| and mplier = |iB|. Magnitude applies only if iSigned=1; otherwise the raw value.
  - mcand is zero-extended to 2*WIDTH. acc=0, count=0. Go to RUN.
- IDLE, iStart=0: stay in IDLE.
- RUN, each cycle:
  - if mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; count += 1.
  - When count reaches WIDTH-1 (i.e. after the WIDTH-th RUN cycle), go to DONE.
  - oResult is written on that same edge: s ? -(acc_next) : acc_next, truncated to 2*WIDTH bits.
- DONE: oDone=1 for exactly one cycle.
  - iStart=1: latch a new request as in IDLE and go to RUN (back-to-back, no idle gap).
  - iStart=0: go to IDLE.
- Latency: iStart sampled at edge k → oDone high in the cycle following edge k+WIDTH. Equivalently, oDone is seen at edge k+WIDTH+1. Fixed at WIDTH+1 edges unless the optional feature below is enabled.
- iStart during RUN is ignored. The operands are not re-sampled.
- Signed magnitude of the most-negative value (0x8000 for WIDTH=16) is 0x8000 treated as unsigned. This is correct; no overflow is possible in 2*WIDTH bits.
- A zero operand produces 0 with s forced irrelevant (-0 = 0).
- oResult is stable between DONE pulses. The ALU takes the low WIDTH bits for rResult.

Optional Feature:
- Macro: MUL_ITERATIVE_EARLY_EXIT_EN.
- Defined: RUN also exits to DONE when the shifted mplier becomes 0 after the current cycle.
  - Number of RUN cycles = index of the highest set bit of |iB| + 1, minimum 1 (iB=0 → 1 RUN cycle).
  - The product value is identical to the fixed-latency result.
- Undefined: always WIDTH RUN cycles; latency is fixed.

Test Plan:
1. Reset asserted mid-RUN (start 7*9, assert Reset at cycle 5) → oBusy=0, oDone never pulses, oResult=0 immediately (async). After release, a new request to IDLE works.
2. Unsigned iA=0x00FF, iB=0x0101, iSigned=0 → oResult=0x0000FFFF. oDone at edge k+17. oBusy high for 16 cycles.
3. Signed iA=0xFFFD (-3), iB=0x0007, iSigned=1 → oResult=0xFFFFFFEB (-21). Same operands with iSigned=0 → 0x0006FFEB.
4. Signed corner iA=0x8000, iB=0x8000, iSigned=1 → oResult=0x40000000. iA=0x8000, iB=0x0001 → 0xFFFF8000.
5. Back-to-back: iStart held high through DONE with 3*4 then 5*6 → two oDone pulses 17 edges apart. oResult is 12 and then 30. iStart pulses during RUN are ignored.
6. With MUL_ITERATIVE_EARLY_EXIT_EN: iA=100, iB=5 → 3 RUN cycles, oDone at edge k+4, oResult=500. iB=0 → oDone at edge k+2, oResult=0.
